ifft_4pt: RTL and testbench
===========================

Name: ifft_4pt

Overview:
- 4-point inverse FFT; the decode partner of fft_4pt. Maps four complex frequency bins back to four complex time samples.
- Uses the same packed complex word format and the same start/done handshake as fft_4pt, so fft_4pt→ifft_4pt round trips work directly.
- Multi-cycle radix-2 datapath: input capture, two butterfly stages, scale-by-1/4, then output register.

Parameters:
- WIDTH, 32, packed complex word width: real in [WIDTH-1:WIDTH/2], imaginary in [WIDTH/2-1:0]. Both halves are signed two's complement. WIDTH must be even and ≥ 8.
- GUARD, 2, extra internal bits per component to prevent butterfly overflow. Must be ≥ 2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- F  input  WIDTH x [0:3]  frequency bins X[0..3], packed {re, im}
- start  input  1  level request; sampled only in IDLE
- f  output  WIDTH x [0:3]  time samples x[0..3], packed {re, im}, registered
- done  output  1  high while result valid and held

Behaviour:
- Reset, asynchronous, while reset=1: state=IDLE, done=0, all f=0, all internal registers 0. Reset overrides everything, including mid-operation; no partial result is ever driven.
- States: IDLE, S1, S2, OUT, DONE.
- IDLE: if start=1 at a clock edge, register F[0..3] into X regs, then go to S1. Otherwise stay.
- S1: a0=X0+X2, a1=X0-X2, a2=X1+X3, a3=X1-X3, component-wise at HALF+GUARD bits (HALF=WIDTH/2), sign-extended. Go to S2.
- S2: y0=a0+a2, y2=a0-a2, y1=a1+j*a3, y3=a1-j*a3. Multiplying by j maps (r,i) to (-i,r). Go to OUT.
- OUT: f[n] <= {y_n.re>>>2, y_n.im>>>2}, arithmetic shift, so rounding is floor toward -inf. Truncate to HALF bits (always fits). done <= 1. Go to DONE.
- DONE: done=1 and f held. If start=0 go to IDLE, and done=0 from that edge. If start=1 stay in DONE, so a held start gives no retrigger.
- Latency: start sampled at edge k; f valid and done=1 after edge k+3. Exactly 4 edges from capture to done.
- start is ignored in S1, S2 and OUT; F changes after capture do not affect the result.
- f keeps the last result through IDLE and the next run until the next OUT edge overwrites it.
- Back-to-back operation: drop start for ≥1 edge in DONE, then raise it again. Minimum period is 5 cycles.
- No overflow is possible: |y| ≤ 4·2^(HALF-1), so after >>>2 the result fits HALF bits. Checks: all bins 32767 gives 32767; all bins -32768 gives -32768.

Test Plan:
- Round trip: F = {700,0},{-100,100},{-100,0},{-100,-100}, start=1 → done rises 4 edges after capture; f = {100,0},{150,0},{200,0},{250,0}.
- Impulse in bin 1: F1={400,0}, others 0 → f0={100,0}, f1={0,100}, f2={-100,0}, f3={0,-100}.
- Rounding: F0={3,0} → all f={0,0}. F0={-3,-5}, others 0 → all f={-1,-2}.
- Extremes: all F={32767,0} → f0={32767,0}, f1..f3={0,0}. All F={-32768,-32768} → f0={-32768,-32768}, others {0,0}. No wrap.
- Handshake: hold start=1 for 20 cycles → exactly one done rise, done stays 1. Drop start → done=0 next edge. Change F and reassert → new result after 4 edges. Toggle F during S1/S2 → result unaffected.
- Reset: assert reset asynchronously in S2 (between edges) → done=0 and f=0 immediately. Release, then start → correct result with normal latency.

Source files
------------

// File: rtl/ifft_4pt.sv
// 4-point radix-2 inverse FFT with start/done handshake; output scaled by 1/4.
// Packed complex words: real in the upper half, imaginary in the lower half.
module ifft_4pt #(
    parameter int WIDTH = 32,
    parameter int GUARD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] F [0:3],
    input  logic             start,
    output logic [WIDTH-1:0] f [0:3],
    output logic             done
);

    localparam int HALF = WIDTH / 2;
    localparam int IW   = HALF + GUARD;

    typedef enum logic [2:0] {IDLE, S1, S2, OUT, DONE} state_t;

    state_t state, state_next;

    logic signed [IW-1:0] xr [0:3];
    logic signed [IW-1:0] xi [0:3];
    logic signed [IW-1:0] ar [0:3];
    logic signed [IW-1:0] ai [0:3];
    logic signed [IW-1:0] yr [0:3];
    logic signed [IW-1:0] yi [0:3];

    function automatic logic signed [IW-1:0] ext(input logic [HALF-1:0] v);
        return {{GUARD{v[HALF-1]}}, v};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = OUT;
            OUT:     state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < 4; n++) begin
                xr[n] <= '0;
                xi[n] <= '0;
                ar[n] <= '0;
                ai[n] <= '0;
                yr[n] <= '0;
                yi[n] <= '0;
                f[n]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned n = 0; n < 4; n++) begin
                            xr[n] <= ext(F[n][WIDTH-1:HALF]);
                            xi[n] <= ext(F[n][HALF-1:0]);
                        end
                    end
                end
                S1: begin
                    ar[0] <= xr[0] + xr[2];
                    ai[0] <= xi[0] + xi[2];
                    ar[1] <= xr[0] - xr[2];
                    ai[1] <= xi[0] - xi[2];
                    ar[2] <= xr[1] + xr[3];
                    ai[2] <= xi[1] + xi[3];
                    ar[3] <= xr[1] - xr[3];
                    ai[3] <= xi[1] - xi[3];
                end
                S2: begin
                    // j*a3 = (-a3.im, a3.re)
                    yr[0] <= ar[0] + ar[2];
                    yi[0] <= ai[0] + ai[2];
                    yr[2] <= ar[0] - ar[2];
                    yi[2] <= ai[0] - ai[2];
                    yr[1] <= ar[1] - ai[3];
                    yi[1] <= ai[1] + ar[3];
                    yr[3] <= ar[1] + ai[3];
                    yi[3] <= ai[1] - ar[3];
                end
                OUT: begin
                    // Taking bits [HALF+1:2] is an arithmetic >>>2 then truncation to HALF bits.
                    for (int unsigned n = 0; n < 4; n++)
                        f[n] <= {yr[n][HALF+1:2], yi[n][HALF+1:2]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_4pt.sv
// Directed self-checking bench for ifft_4pt using hand-computed expected results.
module tb_ifft_4pt;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] F [0:3];
    logic [W-1:0] f [0:3];
    logic         done;

    int checks   = 0;
    int failures = 0;

    ifft_4pt #(.WIDTH(W), .GUARD(2)) dut (
        .clock(clock),
        .reset(reset),
        .F(F),
        .start(start),
        .f(f),
        .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] cw(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        F[0] = a; F[1] = b; F[2] = c; F[3] = d;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_f0"}, f[0], e0);
        check({tag, "_f1"}, f[1], e1);
        check({tag, "_f2"}, f[2], e2);
        check({tag, "_f3"}, f[3], e3);
    endtask

    // Called at a negedge in IDLE with F already driven; returns at a negedge.
    task automatic run(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
        start = 1'b1;
        @(posedge clock);
        for (int e = 0; e < 3; e++) begin
            @(negedge clock);
            check($sformatf("%s_lat%0d", tag, e), {31'b0, done}, 32'd0);
            @(posedge clock);
        end
        @(negedge clock);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check_out(tag, e0, e1, e2, e3);
        start = 1'b0;
        @(negedge clock);
        check({tag, "_drop"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int  rises;
        logic prev;
        set_in('0, '0, '0, '0);
        #2;
        check("rst_done", {31'b0, done}, 32'd0);
        check_out("rst", '0, '0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        set_in(cw(700, 0), cw(-100, 100), cw(-100, 0), cw(-100, -100));
        run("trip", cw(100, 0), cw(150, 0), cw(200, 0), cw(250, 0));

        set_in(cw(0, 0), cw(400, 0), cw(0, 0), cw(0, 0));
        run("imp", cw(100, 0), cw(0, 100), cw(-100, 0), cw(0, -100));

        set_in(cw(3, 0), cw(0, 0), cw(0, 0), cw(0, 0));
        run("rnd_pos", cw(0, 0), cw(0, 0), cw(0, 0), cw(0, 0));

        set_in(cw(-3, -5), cw(0, 0), cw(0, 0), cw(0, 0));
        run("rnd_neg", cw(-1, -2), cw(-1, -2), cw(-1, -2), cw(-1, -2));

        set_in(cw(32767, 0), cw(32767, 0), cw(32767, 0), cw(32767, 0));
        run("max", cw(32767, 0), cw(0, 0), cw(0, 0), cw(0, 0));

        set_in(cw(-32768, -32768), cw(-32768, -32768), cw(-32768, -32768), cw(-32768, -32768));
        run("min", cw(-32768, -32768), cw(0, 0), cw(0, 0), cw(0, 0));

        // Held start: exactly one done rise, no retrigger.
        set_in(cw(700, 0), cw(-100, 100), cw(-100, 0), cw(-100, -100));
        start = 1'b1;
        rises = 0;
        prev  = done;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done && !prev) rises++;
            prev = done;
        end
        check("hold_rises", rises, 32'd1);
        check("hold_done", {31'b0, done}, 32'd1);
        check_out("hold", cw(100, 0), cw(150, 0), cw(200, 0), cw(250, 0));
        start = 1'b0;
        @(negedge clock);
        check("hold_drop", {31'b0, done}, 32'd0);
        check_out("idle_keep", cw(100, 0), cw(150, 0), cw(200, 0), cw(250, 0));

        set_in(cw(0, 0), cw(400, 0), cw(0, 0), cw(0, 0));
        run("rearm", cw(100, 0), cw(0, 100), cw(-100, 0), cw(0, -100));

        // Inputs and start disturbed after capture must not affect the result.
        set_in(cw(-3, -5), cw(0, 0), cw(0, 0), cw(0, 0));
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        set_in(cw(1234, -77), cw(-999, 5), cw(31000, 2), cw(-8, 8));
        start = 1'b0;
        @(negedge clock);
        set_in(cw(5, 5), cw(6, 6), cw(7, 7), cw(8, 8));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("tog_done", {31'b0, done}, 32'd1);
        check_out("tog", cw(-1, -2), cw(-1, -2), cw(-1, -2), cw(-1, -2));
        @(negedge clock);
        check("tog_drop", {31'b0, done}, 32'd0);

        // Asynchronous reset while in S2.
        set_in(cw(700, 0), cw(-100, 100), cw(-100, 0), cw(-100, -100));
        start = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_done", {31'b0, done}, 32'd0);
        check_out("arst", '0, '0, '0, '0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        check("arst_idle", {31'b0, done}, 32'd0);
        run("post_rst", cw(100, 0), cw(150, 0), cw(200, 0), cw(250, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
